// File: rtl/score_digit_scheduler.sv
// score_digit_scheduler
//   Holds a packed-BCD player score and accepts point additions over a
//   valid/ready handshake. An accepted add ripples a decimal carry through
//   the digits one digit per clock, starting at digit 0. A free-running scan
//   walks the digits onto one shared BCD decoder. digit_sel is delayed one
//   extra cycle so that it lines up with the decoder's registered output.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous score clear; highest priority
//   add_valid  point-add request
//   add_value  points to add; values 10..15 are clamped to 9
//   add_ready  add can be accepted this cycle
//   bcd_out    digit currently presented to the shared decoder
//   digit_sel  one-hot digit index, aligned with the decoder output
//   score_bcd  live packed score; digit k sits at [4k+3:4k]
//   overflow   sticky flag; the score wrapped past all nines
module score_digit_scheduler #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    add_valid,
    input  logic [3:0]              add_value,
    output logic                    add_ready,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    overflow
);

    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [KW-1:0] LAST_K   = KW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(SCAN_DIV - 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t                     state;
    logic [NUM_DIGITS-1:0][3:0] digit;
    logic [KW-1:0]              k;
    logic [3:0]                 addend;

    logic [3:0] cur_digit;
    logic [4:0] sum;
    logic [4:0] sum_adj;
    logic [3:0] clamped;

    // Scan state
    logic [DW-1:0] div;
    logic [KW-1:0] idx;
    logic [KW-1:0] idx_d;

    // ------------------------------------------------------------------
    // Add datapath: one digit per cycle. addend holds the clamped value
    // for digit 0 and the carry (1) for all later digits.
    // ------------------------------------------------------------------
    always_comb begin
        cur_digit = digit[k];
        sum       = {1'b0, cur_digit} + {1'b0, addend};
        sum_adj   = sum - 5'd10;
        clamped   = (add_value > 4'd9) ? 4'd9 : add_value;
    end

    // Ready drops while clear is asserted, so a clear and an add in the
    // same cycle never accept the add. It is also held low during reset.
    assign add_ready = (state == IDLE) && !clear && !rst;
    assign score_bcd = digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            digit    <= '0;
            k        <= '0;
            addend   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            // Abandons any add in flight. The scan is left untouched.
            state    <= IDLE;
            digit    <= '0;
            k        <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (add_valid && add_ready) begin
                        addend <= clamped;
                        k      <= '0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    if (sum >= 5'd10) begin
                        digit[k] <= sum_adj[3:0];
                        addend   <= 4'd1;
                        if (k == LAST_K) begin
                            // The carry fell off the top digit. The score
                            // wraps modulo 10^NUM_DIGITS.
                            overflow <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end else begin
                        // No carry, so the higher digits are already final.
                        digit[k] <= sum[3:0];
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan: a divider sets how long each digit holds the decoder. bcd_out
    // samples the live digit every cycle, so partial add results show up
    // too. digit_sel uses the index from one cycle earlier, which matches
    // the decoder's one-cycle register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            idx       <= '0;
            idx_d     <= '0;
            bcd_out   <= 4'd0;
            digit_sel <= '0;
        end else begin
            if (div == LAST_DIV) begin
                div <= '0;
                idx <= (idx == LAST_K) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
            bcd_out   <= digit[idx];
            idx_d     <= idx;
            digit_sel <= NUM_DIGITS'(1) << idx_d;
        end
    end

endmodule

// File: doc/score_digit_scheduler.md
Name: score_digit_scheduler

Overview:
Holds the player score as NUM_DIGITS packed BCD digits and accepts point additions over a valid/ready handshake. Additions ripple a decimal carry through the digits, one digit per clock. Time-multiplexes the digits onto one shared BCD_to_onehot decoder (one registered cycle of latency) using a scan counter. It emits a digit-select strobe aligned with the decoder output, so the LED/segment bank latches the right digit.

Parameters:
NUM_DIGITS, 4, number of BCD score digits (2..8); digit 0 is least significant
SCAN_DIV, 1000, clocks each digit occupies the shared decoder (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous score clear, highest priority
add_valid  in  1  point-add request
add_value  in  4  points to add (BCD 0..9; values 10..15 clamped to 9)
add_ready  out  1  block can accept an add this cycle
bcd_out  out  4  digit currently driven to shared decoder input
digit_sel  out  NUM_DIGITS  one-hot digit index, aligned with decoder onehot output
score_bcd  out  4*NUM_DIGITS  live packed score, digit k at bits [4k+3:4k]
overflow  out  1  sticky: score wrapped past all-9s

Behaviour:
- Reset (async, rst=1): all digits 0, state IDLE, add_ready 0, bcd_out 0, digit_sel 0, overflow 0, scan index 0, divider 0. add_ready is 1 on the first cycle after rst deasserts.
- FSM states:
  - IDLE: add_ready=1 unless clear=1. Accept on add_valid&&add_ready at edge T. Latch the clamped addend, set k=0, go to ADD.
  - ADD: add_ready=0. Each cycle processes digit k: sum = digit[k] + addend (addend = add_value for k=0, else carry 1).
    - sum>=10: digit[k]=sum-10, carry=1. Otherwise digit[k]=sum, carry=0.
    - carry=0 after digit k: go to IDLE (early exit).
    - carry=1 and k=NUM_DIGITS-1: set overflow=1, go to IDLE. The score has wrapped mod 10^NUM_DIGITS.
    - Otherwise k increments.
- Add latency: digit 0 updates at edge T+1. A non-carrying add has add_ready high again in the cycle after T+1. Each extra carry digit adds one cycle. Worst case is NUM_DIGITS cycles.
- clear=1 (any state):
  - At the next edge, digits go to 0, overflow goes to 0, and the state goes to IDLE.
  - Any in-progress ADD is abandoned.
  - add_ready=0 while clear=1, so clear plus add_valid in the same cycle accepts nothing.
  - clear does not disturb the scan.
- Scan:
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - At the terminal count, the scan index increments mod NUM_DIGITS.
  - bcd_out is registered as digit[index] every cycle, so it shows live values, including mid-ADD partial results.
  - digit_sel is one-hot(index) delayed one extra cycle, matching the decoder's registered latency: digit_sel changes one cycle after bcd_out changes.
- score_bcd is combinational from the digit registers.
- Digits stay within 0..9 at all times. No invalid BCD is ever driven to the decoder.

Test Plan:
- Release reset; add_value=7, add_valid one cycle -> score_bcd=0x0007 one cycle after accept, add_ready low exactly one cycle, overflow=0.
- Preload 0x0999 by repeated adds; add 1 -> 0x1000 after 4 ADD cycles (digits 0..3 walked), add_ready low 4 cycles.
- Score 0x9995; add 9 -> score 0x0004, overflow=1 and sticky; next add 1 -> 0x0005, overflow still 1; clear -> 0x0000, overflow=0.
- clear asserted during second ADD cycle of 0x0099+1 -> next edge score 0x0000, IDLE; clear+add_valid same cycle -> add_ready=0, no add taken.
- add_value=4'hC -> treated as 9, score increases by 9.
- SCAN_DIV=4, score 0x4321 -> bcd_out cycles 1,2,3,4 with 4 cycles each. digit_sel=0001,0010,0100,1000, each lagging bcd_out by one cycle. Reset asserted mid-scan -> all outputs 0 immediately (asynchronous).
